// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the fetch/decode front end.
package riscv_pipe_pkg;

  localparam int PC_W    = 15;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_next_pc_mux.sv
// Priority select of the next PC plus IF/ID load/bubble/hold and counter enables.
module if_next_pc_mux
  import riscv_pipe_pkg::*;
#(
  parameter int PC_W = riscv_pipe_pkg::PC_W
) (
  input  fetch_state_t    state,
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            jal,
  input  logic [PC_W-1:0] jal_target,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  output logic [PC_W-1:0] pc_nxt,
  output logic            load,
  output logic            bubble,
  output logic            accept,
  output logic            stall_count
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  always_comb begin
    pc_nxt = pc;
    load   = 1'b0;
    bubble = 1'b0;
    accept = 1'b0;
    if (redirect) begin
      pc_nxt = redirect_target & ALIGN_MASK;
      bubble = 1'b1;
      accept = 1'b1;
    end else if (state != RUN) begin
      bubble = 1'b1;
    end else if (stall) begin
      // Hold everything; a pending JAL stays asserted and is taken once the stall lifts.
      pc_nxt = pc;
    end else if (jal) begin
      pc_nxt = jal_target & ALIGN_MASK;
      bubble = 1'b1;
      accept = 1'b1;
    end else begin
      pc_nxt = pc + PC_W'(4);
      load   = 1'b1;
    end
  end

  assign stall_count = (state == RUN) && stall && !redirect;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM, IF/ID register and performance counters.
module if_stage
  import riscv_pipe_pkg::*;
#(
  parameter int              PC_W     = riscv_pipe_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall_IF,
  input  logic               halt_req,
  input  logic               jal_redirect_ID,
  input  logic [PC_W-1:0]    jal_target_ID,
  input  logic               redirect_EXE,
  input  logic [PC_W-1:0]    redirect_target_EXE,
  output logic [PC_W-3:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_ID,
  output logic [PC_W-1:0]    pc_ID,
  output logic               valid_ID,
  output logic               flush_ID_EXE,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nxt;
  logic            redirect;
  logic            load;
  logic            bubble;
  logic            accept;
  logic            stall_count;

  // reset_n is active-high; while it is asserted no redirect may steer the ROM address.
  assign redirect     = redirect_EXE & ~reset_n;
  assign flush_ID_EXE = redirect;
  assign imem_addr    = pc_nxt[PC_W-1:2];

  if_next_pc_mux #(.PC_W(PC_W)) u_mux (
    .state           (state),
    .pc              (pc),
    .stall           (stall_IF),
    .jal             (jal_redirect_ID),
    .jal_target      (jal_target_ID),
    .redirect        (redirect),
    .redirect_target (redirect_target_EXE),
    .pc_nxt          (pc_nxt),
    .load            (load),
    .bubble          (bubble),
    .accept          (accept),
    .stall_count     (stall_count)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      instr_ID  <= NOP_INSTR;
      pc_ID     <= '0;
      valid_ID  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      pc <= pc_nxt;

      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt_req && !stall_IF && !redirect) state <= HALT;
        HALT:    if (redirect) state <= RUN;
        default: state <= BOOT;
      endcase

      if (bubble) begin
        instr_ID <= NOP_INSTR;
        valid_ID <= 1'b0;
      end else if (load) begin
        instr_ID <= imem_rdata;
        pc_ID    <= pc;
        valid_ID <= 1'b1;
      end

      if (stall_count && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (accept && (flush_cnt != '1))      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a synchronous ROM where ROM[i]=i.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_IF;
  logic        halt_req;
  logic        jal_redirect_ID;
  logic [14:0] jal_target_ID;
  logic        redirect_EXE;
  logic [14:0] redirect_target_EXE;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr_ID;
  logic [14:0] pc_ID;
  logic        valid_ID;
  logic        flush_ID_EXE;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  if_stage dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .stall_IF            (stall_IF),
    .halt_req            (halt_req),
    .jal_redirect_ID     (jal_redirect_ID),
    .jal_target_ID       (jal_target_ID),
    .redirect_EXE        (redirect_EXE),
    .redirect_target_EXE (redirect_target_EXE),
    .imem_addr           (imem_addr),
    .imem_rdata          (imem_rdata),
    .instr_ID            (instr_ID),
    .pc_ID               (pc_ID),
    .valid_ID            (valid_ID),
    .flush_ID_EXE        (flush_ID_EXE),
    .stall_cnt           (stall_cnt),
    .flush_cnt           (flush_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= {19'd0, imem_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_id(input string tag, input logic [14:0] pc, input logic [31:0] ins, input logic v);
    chk({tag, "_pc"}, {17'd0, pc_ID}, {17'd0, pc});
    chk({tag, "_instr"}, instr_ID, ins);
    chk({tag, "_valid"}, {31'd0, valid_ID}, {31'd0, v});
  endtask

  initial begin
    reset_n = 1'b1;
    stall_IF = 0; halt_req = 0; jal_redirect_ID = 0; redirect_EXE = 0;
    jal_target_ID = '0; redirect_target_EXE = '0;
    tick(); tick();
    chk_id("reset", 15'd0, NOP, 1'b0);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("reset_addr", {19'd0, imem_addr}, 32'd0);

    // 1: boot bubble then sequential fetch
    reset_n = 1'b0;
    tick();
    chk("boot_valid", {31'd0, valid_ID}, 32'd0);
    tick(); chk_id("seq0", 15'd0, 32'd0, 1'b1);
    tick(); chk_id("seq1", 15'd4, 32'd1, 1'b1);
    tick(); chk_id("seq2", 15'd8, 32'd2, 1'b1);

    // 2: three stall cycles at pc_ID=8
    stall_IF = 1; #1;
    chk("stall_addr0", {19'd0, imem_addr}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_id("stall_hold", 15'd8, 32'd2, 1'b1);
      chk("stall_addr", {19'd0, imem_addr}, 32'd3);
    end
    chk("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    stall_IF = 0;
    tick(); chk_id("resume", 15'd12, 32'd3, 1'b1);

    // 3: JAL from ID, misaligned target masked to 0x100
    jal_redirect_ID = 1; jal_target_ID = 15'h103; #1;
    chk("jal_addr", {19'd0, imem_addr}, 32'h40);
    tick(); chk_id("jal_bubble", 15'd12, NOP, 1'b0);
    chk("jal_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    jal_redirect_ID = 0;
    tick(); chk_id("jal_tgt", 15'h100, 32'h40, 1'b1);
    tick(); chk_id("jal_tgt4", 15'h104, 32'h41, 1'b1);

    // 4: EXE redirect wins over JAL and stall
    redirect_EXE = 1; redirect_target_EXE = 15'h40;
    jal_redirect_ID = 1; jal_target_ID = 15'h100; stall_IF = 1; #1;
    chk("exe_flush", {31'd0, flush_ID_EXE}, 32'd1);
    chk("exe_addr", {19'd0, imem_addr}, 32'h10);
    tick(); chk_id("exe_bubble", 15'h104, NOP, 1'b0);
    chk("exe_flush_cnt", {16'd0, flush_cnt}, 32'd2);
    chk("exe_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    redirect_EXE = 0; jal_redirect_ID = 0; stall_IF = 0; #1;
    chk("exe_flush_off", {31'd0, flush_ID_EXE}, 32'd0);
    tick(); chk_id("exe_tgt", 15'h40, 32'h10, 1'b1);

    // 5: halt, ignored inputs while halted, restart by EXE redirect
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    chk("halt_valid", {31'd0, valid_ID}, 32'd0);
    chk("halt_addr", {19'd0, imem_addr}, 32'h12);
    jal_redirect_ID = 1; jal_target_ID = 15'h200; stall_IF = 1; halt_req = 1; #1;
    chk("halt_ign_addr", {19'd0, imem_addr}, 32'h12);
    tick();
    chk("halt_ign_valid", {31'd0, valid_ID}, 32'd0);
    chk("halt_ign_flush_cnt", {16'd0, flush_cnt}, 32'd2);
    chk("halt_ign_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    jal_redirect_ID = 0; stall_IF = 0; halt_req = 0;
    redirect_EXE = 1; redirect_target_EXE = 15'h80; #1;
    chk("halt_exit_flush", {31'd0, flush_ID_EXE}, 32'd1);
    chk("halt_exit_addr", {19'd0, imem_addr}, 32'h20);
    tick();
    chk("halt_exit_valid", {31'd0, valid_ID}, 32'd0);
    chk("halt_exit_flush_cnt", {16'd0, flush_cnt}, 32'd3);
    redirect_EXE = 0;
    tick(); chk_id("halt_exit_tgt", 15'h80, 32'h20, 1'b1);

    // 6: drive stall_cnt to saturation, then asynchronous reset mid-cycle
    stall_IF = 1;
    for (int i = 0; i < 16'hFFFE - 3; i++) tick();
    chk("sat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    tick();
    chk("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
    tick();
    chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
    chk_id("sat_pc_hold", 15'h80, 32'h20, 1'b1);
    redirect_EXE = 1; redirect_target_EXE = 15'h300;
    #1 reset_n = 1'b1;
    #1;
    chk_id("mid_reset", 15'd0, NOP, 1'b0);
    chk("mid_reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mid_reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("mid_reset_flush", {31'd0, flush_ID_EXE}, 32'd0);
    chk("mid_reset_addr", {19'd0, imem_addr}, 32'd0);
    redirect_EXE = 0; stall_IF = 0;
    tick();
    reset_n = 1'b0;
    tick();
    chk("rerun_boot_valid", {31'd0, valid_ID}, 32'd0);
    tick(); chk_id("rerun0", 15'd0, 32'd0, 1'b1);
    tick(); chk_id("rerun1", 15'd4, 32'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
